// File: rtl/fifo_gpo_led.sv
// fifo_gpo_led: register-mapped peripheral cluster behind the SPI register wrapper.
//   LED register  : 8-bit, bits 0/1 drive led0/led1.
//   GPO register  : 8-bit, bits [GPO_W-1:0] drive gpo_pins.
//   Byte FIFO     : first-word fall-through, bounded by a programmable transfer
//                   length; flags report a full transfer written / read.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   led_*  / gpo_*                rd/wr strobes, write data, register contents
//   fifo_rd_en / fifo_wr_en       pop / push strobes, fifo_data_in push data
//   fifo_data_out                 head entry (0 when empty)
//   fifo_length_*                 length register strobes, data and contents
//   fifo_full / fifo_read_complete  transfer-length written / read
module fifo_gpo_led #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GPO_W      = 7,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              led_rd_en,
  input  logic              led_wr_en,
  input  logic [DATA_W-1:0] led_data_in,
  output logic [DATA_W-1:0] led_data_out,
  output logic              led0,
  output logic              led1,
  input  logic              gpo_rd_en,
  input  logic              gpo_wr_en,
  input  logic [DATA_W-1:0] gpo_data_in,
  output logic [DATA_W-1:0] gpo_data_out,
  output logic [GPO_W-1:0]  gpo_pins,
  input  logic              fifo_rd_en,
  input  logic              fifo_wr_en,
  input  logic [DATA_W-1:0] fifo_data_in,
  output logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_length_rd_en,
  input  logic              fifo_length_wr_en,
  input  logic [DATA_W-1:0] fifo_length_in,
  output logic [DATA_W-1:0] fifo_length_out,
  output logic              fifo_full,
  output logic              fifo_read_complete
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] led_q;
  logic [DATA_W-1:0] gpo_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  len_next;
  logic              push_ok;
  logic              pop_ok;
  logic              empty;

  // Read strobes have no side effects in this cluster.
  logic unused_rd;
  assign unused_rd = ^{led_rd_en, gpo_rd_en, fifo_length_rd_en};

  // LED and GPO registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= '0;
      gpo_q <= '0;
    end else begin
      if (led_wr_en) led_q <= led_data_in;
      if (gpo_wr_en) gpo_q <= gpo_data_in;
    end
  end

  assign led_data_out = led_q;
  assign led0         = led_q[0];
  assign led1         = led_q[1];
  assign gpo_data_out = gpo_q;
  assign gpo_pins     = gpo_q[GPO_W-1:0];

  // Length clamp; a length write overrides any data strobe in the same cycle.
  always_comb begin
    len_next = CNT_W'(fifo_length_in);
    if (fifo_length_in > DATA_W'(FIFO_DEPTH)) len_next = CNT_W'(FIFO_DEPTH);
  end

  // With no length programmed, total pushes are bounded by the storage size.
  assign push_ok = fifo_wr_en && !fifo_length_wr_en &&
                   ((len != '0) ? (wr_cnt < len) : (wr_cnt < CNT_W'(FIFO_DEPTH)));
  // Pop sees pre-push counts, so a same-cycle push cannot be popped.
  assign pop_ok  = fifo_rd_en && !fifo_length_wr_en && (rd_cnt < wr_cnt);
  assign empty   = (rd_cnt == wr_cnt);

  // FIFO control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len    <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fifo_length_wr_en) begin
      len    <= len_next;
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage; contents are masked by the empty check, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= fifo_data_in;
  end

  assign fifo_data_out      = empty ? '0 : mem[rd_ptr];
  assign fifo_length_out    = DATA_W'(len);
  assign fifo_full          = (len != '0) && (wr_cnt == len);
  assign fifo_read_complete = (len != '0) && (rd_cnt == len);

endmodule

// File: tb/tb_fifo_gpo_led.sv
// Directed self-checking bench for fifo_gpo_led.
module tb_fifo_gpo_led;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       led_rd_en, led_wr_en;
  logic [7:0] led_data_in, led_data_out;
  logic       led0, led1;
  logic       gpo_rd_en, gpo_wr_en;
  logic [7:0] gpo_data_in, gpo_data_out;
  logic [6:0] gpo_pins;
  logic       fifo_rd_en, fifo_wr_en;
  logic [7:0] fifo_data_in, fifo_data_out;
  logic       fifo_length_rd_en, fifo_length_wr_en;
  logic [7:0] fifo_length_in, fifo_length_out;
  logic       fifo_full, fifo_read_complete;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_gpo_led dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .led_rd_en          (led_rd_en),
    .led_wr_en          (led_wr_en),
    .led_data_in        (led_data_in),
    .led_data_out       (led_data_out),
    .led0               (led0),
    .led1               (led1),
    .gpo_rd_en          (gpo_rd_en),
    .gpo_wr_en          (gpo_wr_en),
    .gpo_data_in        (gpo_data_in),
    .gpo_data_out       (gpo_data_out),
    .gpo_pins           (gpo_pins),
    .fifo_rd_en         (fifo_rd_en),
    .fifo_wr_en         (fifo_wr_en),
    .fifo_data_in       (fifo_data_in),
    .fifo_data_out      (fifo_data_out),
    .fifo_length_rd_en  (fifo_length_rd_en),
    .fifo_length_wr_en  (fifo_length_wr_en),
    .fifo_length_in     (fifo_length_in),
    .fifo_length_out    (fifo_length_out),
    .fifo_full          (fifo_full),
    .fifo_read_complete (fifo_read_complete)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply whatever strobes are set for one rising edge, then drop them.
  task automatic tick;
    @(posedge clk);
    #1;
    led_rd_en = 0; led_wr_en = 0; gpo_rd_en = 0; gpo_wr_en = 0;
    fifo_rd_en = 0; fifo_wr_en = 0; fifo_length_rd_en = 0; fifo_length_wr_en = 0;
  endtask

  task automatic set_len(input logic [7:0] l);
    fifo_length_in = l; fifo_length_wr_en = 1; tick();
  endtask

  task automatic push(input logic [7:0] d);
    fifo_data_in = d; fifo_wr_en = 1; tick();
  endtask

  task automatic pop;
    fifo_rd_en = 1; tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " led_data_out"}, led_data_out, 8'h00);
    chk({tag, " leds"}, {6'd0, led1, led0}, 8'h00);
    chk({tag, " gpo_data_out"}, gpo_data_out, 8'h00);
    chk({tag, " gpo_pins"}, {1'b0, gpo_pins}, 8'h00);
    chk({tag, " fifo_data_out"}, fifo_data_out, 8'h00);
    chk({tag, " fifo_length_out"}, fifo_length_out, 8'h00);
    chk({tag, " flags"}, {6'd0, fifo_full, fifo_read_complete}, 8'h00);
  endtask

  initial begin
    reset_n = 0;
    led_rd_en = 0; led_wr_en = 0; led_data_in = 0;
    gpo_rd_en = 0; gpo_wr_en = 0; gpo_data_in = 0;
    fifo_rd_en = 0; fifo_wr_en = 0; fifo_data_in = 0;
    fifo_length_rd_en = 0; fifo_length_wr_en = 0; fifo_length_in = 0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    // LED register
    led_data_in = 8'h03; led_wr_en = 1; tick();
    chk("led_data_out", led_data_out, 8'h03);
    chk("led0_led1", {6'd0, led1, led0}, 8'h03);

    // GPO register and side-effect-free read
    gpo_data_in = 8'hA5; gpo_wr_en = 1; tick();
    chk("gpo_data_out", gpo_data_out, 8'hA5);
    chk("gpo_pins", {1'b0, gpo_pins}, 8'h25);
    gpo_rd_en = 1; tick();
    chk("gpo_after_rd", gpo_data_out, 8'hA5);
    chk("gpo_pins_after_rd", {1'b0, gpo_pins}, 8'h25);

    // Length 3 transfer: fill
    set_len(8'd3);
    chk("len3", fifo_length_out, 8'd3);
    push(8'h01);
    chk("full_after_1", {7'd0, fifo_full}, 8'd0);
    chk("head_after_1", fifo_data_out, 8'h01);
    push(8'h02);
    chk("full_after_2", {7'd0, fifo_full}, 8'd0);
    push(8'h03);
    chk("full_after_3", {7'd0, fifo_full}, 8'd1);
    push(8'h04);
    chk("full_after_drop", {7'd0, fifo_full}, 8'd1);
    chk("head_after_drop", fifo_data_out, 8'h01);

    // Drain
    pop();
    chk("pop1_head", fifo_data_out, 8'h02);
    chk("pop1_rc", {7'd0, fifo_read_complete}, 8'd0);
    pop();
    chk("pop2_head", fifo_data_out, 8'h03);
    pop();
    chk("pop3_head", fifo_data_out, 8'h00);
    chk("pop3_rc", {7'd0, fifo_read_complete}, 8'd1);
    pop();
    chk("extra_pop_head", fifo_data_out, 8'h00);
    chk("extra_pop_rc", {7'd0, fifo_read_complete}, 8'd1);
    chk("extra_pop_full", {7'd0, fifo_full}, 8'd1);

    // Length is clamped to the FIFO depth
    set_len(8'd20);
    chk("len_clamp", fifo_length_out, 8'd16);
    chk("len_clamp_flags", {6'd0, fifo_full, fifo_read_complete}, 8'd0);

    // Simultaneous push and pop
    set_len(8'd4);
    push(8'hAA);
    push(8'hBB);
    fifo_data_in = 8'hCC; fifo_wr_en = 1; fifo_rd_en = 1; tick();
    chk("sim_head", fifo_data_out, 8'hBB);
    chk("sim_full", {7'd0, fifo_full}, 8'd0);
    pop();
    chk("sim_pop_head", fifo_data_out, 8'hCC);
    pop();
    chk("sim_empty_head", fifo_data_out, 8'h00);
    chk("sim_empty_rc", {7'd0, fifo_read_complete}, 8'd0);
    push(8'hDD);
    chk("sim_full4", {7'd0, fifo_full}, 8'd1);
    chk("sim_head_dd", fifo_data_out, 8'hDD);
    pop();
    chk("sim_rc4", {7'd0, fifo_read_complete}, 8'd1);

    // Push and pop on an empty FIFO: no fall-through in the same cycle
    set_len(8'd3);
    fifo_data_in = 8'h55; fifo_wr_en = 1; fifo_rd_en = 1; tick();
    chk("empty_pushpop_head", fifo_data_out, 8'h55);

    // Length write wins over a same-cycle push
    fifo_length_in = 8'd2; fifo_length_wr_en = 1; fifo_data_in = 8'hEE; fifo_wr_en = 1; tick();
    chk("lenwin_len", fifo_length_out, 8'd2);
    chk("lenwin_head", fifo_data_out, 8'h00);

    // Reprogramming length clears progress
    set_len(8'd3);
    push(8'h11);
    push(8'h22);
    set_len(8'd2);
    chk("relen_len", fifo_length_out, 8'd2);
    chk("relen_flags", {6'd0, fifo_full, fifo_read_complete}, 8'd0);
    chk("relen_head", fifo_data_out, 8'h00);
    push(8'h33);
    push(8'h44);
    chk("relen_full", {7'd0, fifo_full}, 8'd1);
    chk("relen_head2", fifo_data_out, 8'h33);

    // Asynchronous reset mid-transfer
    #2;
    reset_n = 0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    // Length 0: no flags, data still flows
    push(8'h66);
    chk("len0_head", fifo_data_out, 8'h66);
    chk("len0_full", {7'd0, fifo_full}, 8'd0);
    pop();
    chk("len0_empty", fifo_data_out, 8'h00);
    chk("len0_rc", {7'd0, fifo_read_complete}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Time bound in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
